// File: rtl/rptr_empty.sv
// Read-side pointer and empty/level tracking for an asynchronous FIFO.
// Keeps binary and Gray read pointers and derives empty, level and underflow.
module rptr_empty #(
    parameter int ptr_width = 9,
    parameter int ae_thresh = 4
) (
    input  logic                 rclk,
    input  logic                 r_rst,
    input  logic                 rinc,
    input  logic [ptr_width:0]   wptr_sync,
    output logic [ptr_width-1:0] raddr,
    output logic [ptr_width:0]   rptr,
    output logic                 rempty,
    output logic                 r_almost_empty,
    output logic [ptr_width:0]   rlevel,
    output logic                 r_underflow
);

    localparam int PW1 = ptr_width + 1;
    localparam logic [ptr_width:0] AE_LIM = PW1'(ae_thresh);

    logic [ptr_width:0] r_bin;
    logic [ptr_width:0] r_gray;
    logic               r_empty;
    logic               r_ae;
    logic [ptr_width:0] r_level;
    logic               r_uf;

    logic               w_rd;
    logic [ptr_width:0] w_bin_next;
    logic [ptr_width:0] w_gray_next;
    logic [ptr_width:0] w_wbin_s;
    logic [ptr_width:0] w_level_next;

    assign w_rd        = rinc & ~r_empty;
    assign w_bin_next  = r_bin + PW1'(w_rd);
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

    // Gray-to-binary: each bit folds in every more-significant Gray bit
    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i < PW1; i++) begin
            w_wbin_s[i] = ^(wptr_sync >> i);
        end
    end

    assign w_level_next = w_wbin_s - w_bin_next;

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_empty <= 1'b1;
            r_ae    <= 1'b1;
            r_level <= '0;
            r_uf    <= 1'b0;
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_gray_next;
            r_empty <= (w_gray_next == wptr_sync);
            r_ae    <= (w_level_next <= AE_LIM);
            r_level <= w_level_next;
            r_uf    <= rinc & r_empty;
        end
    end

    assign raddr          = r_bin[ptr_width-1:0];
    assign rptr           = r_gray;
    assign rempty         = r_empty;
    assign r_almost_empty = r_ae;
    assign rlevel         = r_level;
    assign r_underflow    = r_uf;

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty with ptr_width=3, ae_thresh=2.
// Stimulus queues expected outputs; a monitor pops and compares them.
module tb_rptr_empty;

    typedef struct packed {
        logic [2:0] raddr;
        logic [3:0] rptr;
        logic       empty;
        logic       ae;
        logic [3:0] level;
        logic       uf;
    } exp_t;

    logic       rclk = 1'b0;
    logic       r_rst = 1'b1;
    logic       rinc = 1'b0;
    logic [3:0] wptr_sync = 4'b0000;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       r_almost_empty;
    logic [3:0] rlevel;
    logic       r_underflow;

    exp_t  q[$];
    string tq[$];
    int    errors = 0;
    int    checks = 0;
    event  chk_ev;

    rptr_empty #(.ptr_width(3), .ae_thresh(2)) dut (
        .rclk           (rclk),
        .r_rst          (r_rst),
        .rinc           (rinc),
        .wptr_sync      (wptr_sync),
        .raddr          (raddr),
        .rptr           (rptr),
        .rempty         (rempty),
        .r_almost_empty (r_almost_empty),
        .rlevel         (rlevel),
        .r_underflow    (r_underflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [3:0] g(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic exp_t mk(input logic [2:0] a, input logic [3:0] p,
                                input logic e, input logic ae,
                                input logic [3:0] l, input logic u);
        exp_t r;
        r.raddr = a; r.rptr = p; r.empty = e;
        r.ae = ae; r.level = l; r.uf = u;
        return r;
    endfunction

    task automatic step(input logic inc, input logic [3:0] w,
                        input exp_t e, input string tag);
        @(negedge rclk);
        rinc = inc;
        wptr_sync = w;
        q.push_back(e);
        tq.push_back(tag);
        @(posedge rclk);
    endtask

    // Monitor: compares the oldest queued expectation after each edge
    initial begin
        exp_t  e;
        exp_t  a;
        string t;
        forever begin
            @(posedge rclk or chk_ev);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                t = tq.pop_front();
                a = mk(raddr, rptr, rempty, r_almost_empty, rlevel, r_underflow);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got raddr=%0d rptr=%b empty=%b ae=%b level=%0d uf=%b, want raddr=%0d rptr=%b empty=%b ae=%b level=%0d uf=%b",
                             t, a.raddr, a.rptr, a.empty, a.ae, a.level, a.uf,
                             e.raddr, e.rptr, e.empty, e.ae, e.level, e.uf);
                end
            end
        end
    end

    initial begin
        logic [3:0] b;
        logic [3:0] k;
        exp_t rst_e;
        rst_e = mk(3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);

        #12;
        q.push_back(rst_e); tq.push_back("reset_state");
        -> chk_ev;
        #3;
        @(negedge rclk);
        r_rst = 1'b0;

        step(0, 4'b0000, rst_e, "idle_empty");
        step(0, 4'b0010, mk(3'd0, 4'b0000, 0, 0, 4'd3, 0), "fill3");
        step(1, 4'b0010, mk(3'd1, 4'b0001, 0, 1, 4'd2, 0), "read1");
        step(1, 4'b0010, mk(3'd2, 4'b0011, 0, 1, 4'd1, 0), "read2");
        step(1, 4'b0010, mk(3'd3, 4'b0010, 1, 1, 4'd0, 0), "read3_empty");
        step(1, 4'b0010, mk(3'd3, 4'b0010, 1, 1, 4'd0, 1), "underflow");
        step(0, 4'b0010, mk(3'd3, 4'b0010, 1, 1, 4'd0, 0), "uf_clear");
        step(0, 4'b0110, mk(3'd3, 4'b0010, 0, 1, 4'd1, 0), "level1");
        step(1, 4'b0111, mk(3'd4, 4'b0110, 0, 1, 4'd1, 0), "simul");
        step(1, 4'b0111, mk(3'd5, 4'b0111, 1, 1, 4'd0, 0), "drain_rbin5");
        step(0, 4'b0100, mk(3'd5, 4'b0111, 0, 1, 4'd2, 0), "level2");

        @(negedge rclk);
        #1;
        rinc = 1'b1;
        r_rst = 1'b1;
        #1;
        q.push_back(rst_e); tq.push_back("async_reset");
        -> chk_ev;
        @(posedge rclk);
        step(1, 4'b0101, rst_e, "reset_hold");
        @(negedge rclk);
        rinc = 1'b0;
        wptr_sync = 4'b0000;
        r_rst = 1'b0;

        step(0, 4'b1100, mk(3'd0, 4'b0000, 0, 0, 4'd8, 0), "full8");
        for (int i = 1; i <= 8; i++) begin
            k = 4'(i);
            step(1, 4'b1100,
                 mk(k[2:0], g(k), (i == 8), (8 - i <= 2), 4'(8 - i), 0),
                 "drain_full");
        end

        b = 4'd8;
        for (int i = 0; i < 20; i++) begin
            step(0, g(b + 4'd1), mk(b[2:0], g(b), 0, 1, 4'd1, 0), "wrap_write");
            b = b + 4'd1;
            step(1, g(b), mk(b[2:0], g(b), 1, 1, 4'd0, 0), "wrap_read");
        end

        repeat (3) @(posedge rclk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
